// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with run-time frame format (5..DATA_W data bits, none/odd/even parity, 1/2 stop bits).
// Latency: rx_valid rises 1 clk after the rx_tick that samples the middle of the last stop bit.
// Backpressure: the word is held on rx_valid until rx_ready; a new frame overwrites it and raises overrun_err.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   rx_tick             one-clk strobe at OVERSAMPLE x baud
//   rx_in               asynchronous serial line, idle high
//   enable              receiver enable; low aborts any frame in progress
//   parity_type         00/11 none, 01 odd, 10 even
//   frame_length        data bits per frame, clamped to 5..DATA_W
//   stop_bit_type       0 one stop bit, 1 two stop bits
//   rx_data/rx_valid    held output word, right-justified
//   rx_ready            consumer accept
//   parity_err, frame_err, overrun_err   status of the held word
//   rx_busy             receiver is inside a frame
module uart_rx_param #(
  parameter int DATA_W     = 9,
  parameter int OVERSAMPLE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_tick,
  input  logic              rx_in,
  input  logic              enable,
  input  logic [1:0]        parity_type,
  input  logic [3:0]        frame_length,
  input  logic              stop_bit_type,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun_err,
  output logic              rx_busy
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [3:0]      MIN_LEN = 4'd5;
  localparam logic [3:0]      MAX_LEN = 4'(DATA_W);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t            state;
  logic [1:0]        sync_q;
  logic              line;
  logic [OS_W-1:0]   os_cnt;
  logic [3:0]        bit_cnt;
  logic [DATA_W-1:0] shift_word;
  logic              par_acc;
  logic              par_err_pend;
  logic              frame_err_pend;

  // frame format captured at start-bit detection
  logic [3:0]        len_q;
  logic              par_en_q;
  logic              par_odd_q;
  logic              two_stop_q;

  logic [3:0]        len_clamped;
  logic              last_sample;
  logic              commit;

  assign line        = sync_q[1];
  assign rx_busy     = (state != IDLE);
  assign last_sample = rx_tick && (os_cnt == OS_LAST);
  // The final stop sample completes the frame; a disabled receiver never commits.
  assign commit      = enable && last_sample &&
                       ((state == STOP1 && !two_stop_q) || state == STOP2);

  always_comb begin
    len_clamped = frame_length;
    if (frame_length < MIN_LEN)
      len_clamped = MIN_LEN;
    else if (frame_length > MAX_LEN)
      len_clamped = MAX_LEN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      sync_q         <= 2'b11;
      os_cnt         <= '0;
      bit_cnt        <= '0;
      shift_word     <= '0;
      par_acc        <= 1'b0;
      par_err_pend   <= 1'b0;
      frame_err_pend <= 1'b0;
      len_q          <= MIN_LEN;
      par_en_q       <= 1'b0;
      par_odd_q      <= 1'b0;
      two_stop_q     <= 1'b0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      parity_err     <= 1'b0;
      frame_err      <= 1'b0;
      overrun_err    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx_in};

      // Output holding register. A commit wins over a same-clk accept.
      if (commit) begin
        rx_data     <= shift_word;
        rx_valid    <= 1'b1;
        parity_err  <= par_err_pend;
        frame_err   <= frame_err_pend | ~line;
        overrun_err <= rx_valid && !rx_ready;
      end else if (rx_valid && rx_ready) begin
        rx_valid    <= 1'b0;
        parity_err  <= 1'b0;
        frame_err   <= 1'b0;
        overrun_err <= 1'b0;
      end

      if (!enable) begin
        state <= IDLE;
      end else if (rx_tick) begin
        case (state)
          IDLE: begin
            if (!line) begin
              state      <= START;
              os_cnt     <= '0;
              len_q      <= len_clamped;
              par_en_q   <= (parity_type == 2'b01) || (parity_type == 2'b10);
              par_odd_q  <= (parity_type == 2'b01);
              two_stop_q <= stop_bit_type;
            end
          end
          START: begin
            if (os_cnt == OS_MID) begin
              // a start bit that is high again at mid-bit was a glitch
              if (!line) begin
                state          <= DATA;
                os_cnt         <= '0;
                bit_cnt        <= '0;
                shift_word     <= '0;
                par_acc        <= 1'b0;
                par_err_pend   <= 1'b0;
                frame_err_pend <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
          DATA: begin
            if (os_cnt == OS_LAST) begin
              os_cnt              <= '0;
              shift_word[bit_cnt] <= line;
              par_acc             <= par_acc ^ line;
              bit_cnt             <= bit_cnt + 4'd1;
              if (bit_cnt == len_q - 4'd1)
                state <= par_en_q ? PARITY : STOP1;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
          PARITY: begin
            if (os_cnt == OS_LAST) begin
              os_cnt <= '0;
              // par_acc ^ line is 1 when the total count of ones is odd
              par_err_pend <= par_odd_q ? ~(par_acc ^ line) : (par_acc ^ line);
              state        <= STOP1;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
          STOP1: begin
            if (os_cnt == OS_LAST) begin
              os_cnt <= '0;
              if (!line)
                frame_err_pend <= 1'b1;
              state <= two_stop_q ? STOP2 : IDLE;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
          STOP2: begin
            if (os_cnt == OS_LAST) begin
              os_cnt <= '0;
              state  <= IDLE;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

  localparam int DATA_W     = 9;
  localparam int OVERSAMPLE = 16;
  localparam int TDIV       = 2;
  localparam int BIT        = OVERSAMPLE * TDIV;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_tick;
  logic              rx_in;
  logic              enable;
  logic [1:0]        parity_type;
  logic [3:0]        frame_length;
  logic              stop_bit_type;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              parity_err;
  logic              frame_err;
  logic              overrun_err;
  logic              rx_busy;

  int n_chk  = 0;
  int n_fail = 0;

  uart_rx_param #(.DATA_W(DATA_W), .OVERSAMPLE(OVERSAMPLE)) dut (
    .clk(clk), .rst(rst), .rx_tick(rx_tick), .rx_in(rx_in), .enable(enable),
    .parity_type(parity_type), .frame_length(frame_length), .stop_bit_type(stop_bit_type),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun_err(overrun_err),
    .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  // baud tick: one clk high every TDIV clks
  initial begin
    int ph;
    ph = 0;
    rx_tick = 1'b0;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % TDIV;
      rx_tick = (ph == 0);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observed words: a word is new when rx_valid is seen high and the
  // previous one was either absent or accepted on this same clk.
  typedef struct {
    logic [DATA_W-1:0] d;
    logic pe, fe, oe;
  } obs_t;
  obs_t obs_q[$];
  logic prev_v    = 1'b0;
  logic busy_seen = 1'b0;

  always begin
    @(posedge clk);
    #1;
    if (rx_valid && (!prev_v || rx_ready))
      obs_q.push_back('{rx_data, parity_err, frame_err, overrun_err});
    if (rx_busy) busy_seen = 1'b1;
    prev_v = rx_valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int clamp_len(input int len);
    if (len < 5) return 5;
    if (len > DATA_W) return DATA_W;
    return len;
  endfunction

  task automatic drive_bit(input logic v, input int clks);
    rx_in = v;
    repeat (clks) @(negedge clk);
  endtask

  // Build and drive one frame from its parameters. A bad stop bit is low
  // for 3/4 of the bit only, so the line is back high before a following
  // start-bit check could mistake it for a new frame.
  task automatic send_frame(input logic [14:0] data, input int len, input logic [1:0] ptype,
                            input logic two, input logic bad_par, input logic [1:0] bad_stop);
    int eff;
    logic ones_odd;
    eff = clamp_len(len);
    parity_type   = ptype;
    frame_length  = 4'(len);
    stop_bit_type = two;
    ones_odd = 1'b0;
    drive_bit(1'b0, BIT);
    for (int i = 0; i < eff; i++) begin
      ones_odd ^= data[i];
      drive_bit(data[i], BIT);
    end
    if (ptype == 2'b01) drive_bit(~ones_odd ^ bad_par, BIT);
    if (ptype == 2'b10) drive_bit(ones_odd ^ bad_par, BIT);
    if (bad_stop[0]) begin drive_bit(1'b0, BIT * 3 / 4); drive_bit(1'b1, BIT / 4); end
    else drive_bit(1'b1, BIT);
    if (two) begin
      if (bad_stop[1]) begin drive_bit(1'b0, BIT * 3 / 4); drive_bit(1'b1, BIT / 4); end
      else drive_bit(1'b1, BIT);
    end
    drive_bit(1'b1, 2 * BIT);
  endtask

  task automatic expect_word(input string tag, input logic [DATA_W-1:0] d,
                             input logic pe, input logic fe, input logic oe);
    obs_t o;
    chk({tag, "_count"}, obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      chk({tag, "_data"}, o.d, d);
      chk({tag, "_perr"}, o.pe, pe);
      chk({tag, "_ferr"}, o.fe, fe);
      chk({tag, "_oerr"}, o.oe, oe);
    end
    obs_q.delete();
  endtask

  typedef struct {
    logic [14:0]       data;
    int                len;
    logic [1:0]        ptype;
    logic              two;
    logic              bad_par;
    logic [1:0]        bad_stop;
    logic [DATA_W-1:0] exp_data;
    logic              exp_pe;
    logic              exp_fe;
  } vec_t;

  vec_t vec[12];

  initial begin
    vec[0]  = '{15'h0A5, 8,  2'd0, 1'b0, 1'b0, 2'b00, 9'h0A5, 1'b0, 1'b0}; // 8N1
    vec[1]  = '{15'h041, 7,  2'd2, 1'b1, 1'b1, 2'b00, 9'h041, 1'b1, 1'b0}; // 7E2 wrong parity
    vec[2]  = '{15'h041, 7,  2'd2, 1'b1, 1'b0, 2'b00, 9'h041, 1'b0, 1'b0}; // 7E2 good
    vec[3]  = '{15'h03C, 8,  2'd0, 1'b0, 1'b0, 2'b01, 9'h03C, 1'b0, 1'b1}; // stop low
    vec[4]  = '{15'h03C, 8,  2'd0, 1'b0, 1'b0, 2'b00, 9'h03C, 1'b0, 1'b0}; // clears frame_err
    vec[5]  = '{15'h1FF, 9,  2'd1, 1'b0, 1'b0, 2'b00, 9'h1FF, 1'b0, 1'b0}; // 9O1
    vec[6]  = '{15'h1FF, 9,  2'd1, 1'b0, 1'b1, 2'b00, 9'h1FF, 1'b1, 1'b0}; // 9O1 wrong parity
    vec[7]  = '{15'h7FF, 3,  2'd0, 1'b0, 1'b0, 2'b00, 9'h01F, 1'b0, 1'b0}; // clamp up to 5
    vec[8]  = '{15'h2AB, 12, 2'd0, 1'b0, 1'b0, 2'b00, 9'h0AB, 1'b0, 1'b0}; // clamp down to 9
    vec[9]  = '{15'h055, 8,  2'd2, 1'b1, 1'b0, 2'b10, 9'h055, 1'b0, 1'b1}; // second stop low
    vec[10] = '{15'h013, 5,  2'd1, 1'b0, 1'b0, 2'b00, 9'h013, 1'b0, 1'b0}; // 5O1
    vec[11] = '{15'h066, 8,  2'd3, 1'b0, 1'b1, 2'b00, 9'h066, 1'b0, 1'b0}; // type 11 = none

    rst = 1'b1; rx_in = 1'b1; enable = 1'b1; rx_ready = 1'b1;
    parity_type = 2'd0; frame_length = 4'd8; stop_bit_type = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_data", rx_data, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_errs", {parity_err, frame_err, overrun_err}, 0);
    chk("rst_busy", rx_busy, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    obs_q.delete();

    // table-driven frames
    for (int i = 0; i < 12; i++) begin
      send_frame(vec[i].data, vec[i].len, vec[i].ptype, vec[i].two, vec[i].bad_par, vec[i].bad_stop);
      expect_word($sformatf("vec%0d", i), vec[i].exp_data, vec[i].exp_pe, vec[i].exp_fe, 1'b0);
      chk($sformatf("vec%0d_busy_idle", i), rx_busy, 0);
      chk($sformatf("vec%0d_valid_drop", i), rx_valid, 0);
    end

    // short low glitch on an idle line
    busy_seen = 1'b0;
    obs_q.delete();
    drive_bit(1'b0, 3 * TDIV);
    drive_bit(1'b1, 2 * BIT);
    chk("glitch_busy_pulse", busy_seen, 1);
    chk("glitch_busy_end", rx_busy, 0);
    chk("glitch_valid", rx_valid, 0);
    chk("glitch_words", obs_q.size(), 0);

    // overrun: two words with no consumer
    rx_ready = 1'b0;
    send_frame(15'h011, 8, 2'd0, 1'b0, 1'b0, 2'b00);
    expect_word("ovr_first", 9'h011, 1'b0, 1'b0, 1'b0);
    send_frame(15'h022, 8, 2'd0, 1'b0, 1'b0, 2'b00);
    chk("ovr_data", rx_data, 9'h022);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_flag", overrun_err, 1);
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("ovr_accept_valid", rx_valid, 0);
    chk("ovr_accept_flag", overrun_err, 0);
    obs_q.delete();

    // reset in the middle of DATA
    parity_type = 2'd0; frame_length = 4'd8; stop_bit_type = 1'b0;
    drive_bit(1'b0, BIT);
    drive_bit(1'b1, BIT);
    drive_bit(1'b0, BIT);
    drive_bit(1'b1, BIT / 2);
    chk("rstmid_busy_before", rx_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_busy", rx_busy, 0);
    chk("rstmid_data", rx_data, 0);
    chk("rstmid_valid", rx_valid, 0);
    drive_bit(1'b1, 3 * BIT);
    chk("rstmid_words", obs_q.size(), 0);
    send_frame(15'h05C, 8, 2'd0, 1'b0, 1'b0, 2'b00);
    expect_word("rstmid_next", 9'h05C, 1'b0, 1'b0, 1'b0);

    // enable dropped in the middle of DATA
    drive_bit(1'b0, BIT);
    drive_bit(1'b1, BIT);
    drive_bit(1'b0, BIT / 2);
    chk("enmid_busy_before", rx_busy, 1);
    enable = 1'b0;
    rx_in  = 1'b1;
    @(negedge clk);
    chk("enmid_busy", rx_busy, 0);
    chk("enmid_data_kept", rx_data, 9'h05C);
    repeat (4) @(negedge clk);
    enable = 1'b1;
    drive_bit(1'b1, 3 * BIT);
    chk("enmid_words", obs_q.size(), 0);
    send_frame(15'h0A3, 8, 2'd1, 1'b1, 1'b0, 2'b00);
    expect_word("enmid_next", 9'h0A3, 1'b0, 1'b0, 1'b0);

    // randomized frames against the reference rules
    for (int k = 0; k < 14; k++) begin
      logic [14:0] d;
      int len, eff;
      logic [1:0] pt, bs;
      logic two, bp;
      logic [DATA_W-1:0] exp_d;
      d   = 15'($urandom);
      len = $urandom_range(0, 15);
      pt  = 2'($urandom_range(0, 3));
      two = 1'($urandom_range(0, 1));
      bp  = ($urandom_range(0, 3) == 0);
      bs  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      eff = clamp_len(len);
      exp_d = DATA_W'(int'(d) & ((1 << eff) - 1));
      send_frame(d, len, pt, two, bp, bs);
      expect_word($sformatf("rnd%0d", k), exp_d,
                  (pt == 2'b01 || pt == 2'b10) && bp,
                  bs[0] || (two && bs[1]), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
